// File: rtl/alu_multicycle_if.sv
// Handshake/operand bundle for alu_multicycle: request side (master) and ALU side (slave).
interface alu_multicycle_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [3:0]       op;
    logic [WIDTH-1:0] Rb;
    logic [WIDTH-1:0] Ry;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] resultLo;
    logic [WIDTH-1:0] resultHi;
    logic             div_by_zero;

    modport master (
        output start, op, Rb, Ry,
        input  busy, done, resultLo, resultHi, div_by_zero
    );

    modport slave (
        input  start, op, Rb, Ry,
        output busy, done, resultLo, resultHi, div_by_zero
    );
endinterface

// File: rtl/alu_multicycle.sv
// Multi-cycle ALU: one-cycle logic/arith/shift ops, WIDTH-cycle Booth MUL and non-restoring DIV.
// Define ALU_DIV_EN to compile in the divider, DIV state and div_by_zero; otherwise op 12 yields 0.
module alu_multicycle #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SH_W  = $clog2(WIDTH)
) (
    input logic              clock,
    input logic              clear,
    alu_multicycle_if.slave  bus
);
    localparam int unsigned CNT_W = SH_W;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DONE    = 2'd1,
        MUL_RUN = 2'd2
`ifdef ALU_DIV_EN
        , DIV_RUN = 2'd3
`endif
    } state_t;

    typedef enum logic [3:0] {
        OP_AND  = 4'd0,  OP_OR   = 4'd1,  OP_ADD  = 4'd2,  OP_SUB  = 4'd3,
        OP_SHR  = 4'd4,  OP_SHRA = 4'd5,  OP_SHL  = 4'd6,  OP_ROR  = 4'd7,
        OP_ROL  = 4'd8,  OP_NEG  = 4'd9,  OP_NOT  = 4'd10, OP_MUL  = 4'd11,
        OP_DIV  = 4'd12
    } op_t;

    state_t            state, state_nx;
    op_t               op_in;
    logic [CNT_W-1:0]  count;
    logic [WIDTH-1:0]  res_lo, res_hi;
    logic [WIDTH-1:0]  one_lo, one_hi;
    logic [SH_W-1:0]   sh, rol_sh;
    logic [2*WIDTH-1:0] rot2;

    // Booth state: accumulator carries one guard bit so a most-negative multiplicand cannot overflow
    logic [WIDTH:0]    acc, mcand, acc_add, acc_nx;
    logic [WIDTH-1:0]  mq, mq_nx;
    logic              q1;

    assign op_in  = op_t'(bus.op);
    assign sh     = bus.Ry[SH_W-1:0];
    assign rol_sh = SH_W'(0) - sh;
    assign rot2   = {bus.Rb, bus.Rb};

    always_comb begin
        one_lo = '0;
        case (op_in)
            OP_AND:  one_lo = bus.Rb & bus.Ry;
            OP_OR:   one_lo = bus.Rb | bus.Ry;
            OP_ADD:  one_lo = bus.Rb + bus.Ry;
            OP_SUB:  one_lo = bus.Rb - bus.Ry;
            OP_SHR:  one_lo = bus.Rb >> sh;
            OP_SHRA: one_lo = $signed(bus.Rb) >>> sh;
            OP_SHL:  one_lo = bus.Rb << sh;
            OP_ROR:  one_lo = WIDTH'(rot2 >> sh);
            OP_ROL:  one_lo = WIDTH'(rot2 >> rol_sh);
            OP_NEG:  one_lo = -bus.Ry;
            OP_NOT:  one_lo = ~bus.Ry;
            default: one_lo = '0;
        endcase
    end

    always_comb begin
        case ({mq[0], q1})
            2'b01:   acc_add = acc + mcand;
            2'b10:   acc_add = acc - mcand;
            default: acc_add = acc;
        endcase
        acc_nx = {acc_add[WIDTH], acc_add[WIDTH:1]};
        mq_nx  = {acc_add[0], mq[WIDTH-1:1]};
    end

`ifdef ALU_DIV_EN
    // Divider runs on magnitudes; signs are restored on the final step
    logic [WIDTH+1:0]  rem, rem_sh, rem_step;
    logic [WIDTH-1:0]  dq, dq_nx, dvs, rem_fix, quot, rmd, abs_rb, abs_ry;
    logic              neg_q, neg_r, dbz, dbz_now;

    assign abs_rb  = bus.Rb[WIDTH-1] ? -bus.Rb : bus.Rb;
    assign abs_ry  = bus.Ry[WIDTH-1] ? -bus.Ry : bus.Ry;
    assign dbz_now = (op_in == OP_DIV) && (bus.Ry == '0);
    assign one_hi  = dbz_now ? bus.Rb : '0;

    always_comb begin
        rem_sh   = {rem[WIDTH:0], dq[WIDTH-1]};
        rem_step = rem[WIDTH+1] ? rem_sh + {2'b00, dvs} : rem_sh - {2'b00, dvs};
        dq_nx    = {dq[WIDTH-2:0], ~rem_step[WIDTH+1]};
        rem_fix  = rem_step[WIDTH+1] ? rem_step[WIDTH-1:0] + dvs : rem_step[WIDTH-1:0];
        quot     = neg_q ? -dq_nx : dq_nx;
        rmd      = neg_r ? -rem_fix : rem_fix;
    end

    assign bus.div_by_zero = dbz;
`else
    assign one_hi          = '0;
    assign bus.div_by_zero = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (clear) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    if (op_in == OP_MUL) state_nx = MUL_RUN;
`ifdef ALU_DIV_EN
                    else if (op_in == OP_DIV && bus.Ry != '0) state_nx = DIV_RUN;
`endif
                    else state_nx = DONE;
                end
            end
            MUL_RUN: if (count == '0) state_nx = DONE;
`ifdef ALU_DIV_EN
            DIV_RUN: if (count == '0) state_nx = DONE;
`endif
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            count  <= '0;
            res_lo <= '0;
            res_hi <= '0;
            acc    <= '0;
            mcand  <= '0;
            mq     <= '0;
            q1     <= 1'b0;
`ifdef ALU_DIV_EN
            rem    <= '0;
            dq     <= '0;
            dvs    <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            dbz    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        count <= CNT_W'(WIDTH - 1);
                        acc   <= '0;
                        mcand <= {bus.Rb[WIDTH-1], bus.Rb};
                        mq    <= bus.Ry;
                        q1    <= 1'b0;
`ifdef ALU_DIV_EN
                        rem   <= '0;
                        dq    <= abs_rb;
                        dvs   <= abs_ry;
                        neg_q <= bus.Rb[WIDTH-1] ^ bus.Ry[WIDTH-1];
                        neg_r <= bus.Rb[WIDTH-1];
                        dbz   <= dbz_now;
`endif
                        if (state_nx == DONE) begin
                            res_lo <= one_lo;
                            res_hi <= one_hi;
                        end
                    end
                end
                MUL_RUN: begin
                    acc <= acc_nx;
                    mq  <= mq_nx;
                    q1  <= mq[0];
                    if (count == '0) begin
                        res_hi <= acc_nx[WIDTH-1:0];
                        res_lo <= mq_nx;
                    end else begin
                        count <= count - CNT_W'(1);
                    end
                end
`ifdef ALU_DIV_EN
                DIV_RUN: begin
                    rem <= rem_step;
                    dq  <= dq_nx;
                    if (count == '0) begin
                        res_lo <= quot;
                        res_hi <= rmd;
                    end else begin
                        count <= count - CNT_W'(1);
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    assign bus.busy     = (state != IDLE);
    assign bus.done     = (state == DONE);
    assign bus.resultLo = res_lo;
    assign bus.resultHi = res_hi;
endmodule
